// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target front end for a 32-byte register window.
// Define LPC_IO_PORT80_EN to snoop POST-code writes to I/O 0x0080.
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR  = 16'h0800,
    parameter int unsigned SYNC_WAITS = 0
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LpcFrame_n,
    input  logic [3:0] LadIn,
    output logic [3:0] LadOut,
    output logic       LadOe,
    output logic [7:0] AddrReg,
    output logic [7:0] DataWr,
    output logic       WrStrobe,
    input  logic [7:0] DataRd,
    output logic [7:0] Port80Code,
    output logic       Port80Valid
);
    typedef enum logic [3:0] {
        IDLE, CYCTYPE, ADDR, WDATA, HTAR,
        SYNC, RDATA, TTAR, IGNORE
    } state_t;

    localparam logic [3:0] WAITS = 4'(SYNC_WAITS);
    localparam logic [3:0] FIRST_SYNC =
        (SYNC_WAITS == 0) ? 4'h0 : 4'h6;

    state_t      state;
    logic [3:0]  cnt;
    logic        isWrite;
    logic        snooping;
    logic [11:0] addrHi;
    logic [3:0]  wrLo;
    logic [3:0]  rdHi;
    logic [15:0] fullAddr;
    logic        hit;
    logic        snoop;

    assign fullAddr = {addrHi, LadIn};
    assign hit = fullAddr[15:5] == BASE_ADDR[15:5];

`ifdef LPC_IO_PORT80_EN
    assign snoop = isWrite && (fullAddr == 16'h0080);
`else
    assign snoop = 1'b0;
    assign Port80Code = 8'h00;
    assign Port80Valid = 1'b0;
`endif

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state    <= IDLE;
            cnt      <= 4'h0;
            isWrite  <= 1'b0;
            snooping <= 1'b0;
            addrHi   <= 12'h000;
            wrLo     <= 4'h0;
            rdHi     <= 4'h0;
            LadOut   <= 4'hF;
            LadOe    <= 1'b0;
            AddrReg  <= 8'h00;
            DataWr   <= 8'h00;
            WrStrobe <= 1'b0;
`ifdef LPC_IO_PORT80_EN
            Port80Code  <= 8'h00;
            Port80Valid <= 1'b0;
`endif
        end else begin
            WrStrobe <= 1'b0;
`ifdef LPC_IO_PORT80_EN
            Port80Valid <= 1'b0;
`endif
            // LFRAME# low always wins: abort, or (re)start
            if (!LpcFrame_n) begin
                state  <= (LadIn == 4'h0) ? CYCTYPE : IGNORE;
                LadOe  <= 1'b0;
                LadOut <= 4'hF;
                cnt    <= 4'h0;
            end else begin
                unique case (state)
                    IDLE: ;
                    CYCTYPE: begin
                        cnt <= 4'h0;
                        if (LadIn[3:2] == 2'b00) begin
                            isWrite <= LadIn[1];
                            state   <= ADDR;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    ADDR: begin
                        addrHi <= fullAddr[11:0];
                        cnt    <= cnt + 4'h1;
                        if (cnt == 4'h3) begin
                            cnt      <= 4'h0;
                            snooping <= snoop;
                            if (snoop) begin
                                state <= WDATA;
                            end else if (hit) begin
                                AddrReg <= {3'b000, fullAddr[4:0]};
                                state   <= isWrite ? WDATA : HTAR;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    WDATA: begin
                        if (cnt == 4'h0) begin
                            wrLo <= LadIn;
                            cnt  <= 4'h1;
                        end else if (snooping) begin
`ifdef LPC_IO_PORT80_EN
                            Port80Code  <= {LadIn, wrLo};
                            Port80Valid <= 1'b1;
`endif
                            state <= IGNORE;
                        end else begin
                            DataWr   <= {LadIn, wrLo};
                            WrStrobe <= 1'b1;
                            cnt      <= 4'h0;
                            state    <= HTAR;
                        end
                    end
                    HTAR: begin
                        if (cnt == 4'h0) begin
                            cnt <= 4'h1;
                        end else begin
                            cnt    <= 4'h0;
                            LadOe  <= 1'b1;
                            LadOut <= FIRST_SYNC;
                            state  <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (cnt == WAITS) begin
                            cnt <= 4'h0;
                            if (isWrite) begin
                                LadOut <= 4'hF;
                                state  <= TTAR;
                            end else begin
                                rdHi   <= DataRd[7:4];
                                LadOut <= DataRd[3:0];
                                state  <= RDATA;
                            end
                        end else begin
                            cnt    <= cnt + 4'h1;
                            LadOut <= (cnt + 4'h1 == WAITS) ?
                                      4'h0 : 4'h6;
                        end
                    end
                    RDATA: begin
                        if (cnt == 4'h0) begin
                            LadOut <= rdHi;
                            cnt    <= 4'h1;
                        end else begin
                            LadOut <= 4'hF;
                            cnt    <= 4'h0;
                            state  <= TTAR;
                        end
                    end
                    TTAR: begin
                        if (cnt == 4'h0) begin
                            LadOe <= 1'b0;
                            cnt   <= 4'h1;
                        end else begin
                            cnt   <= 4'h0;
                            state <= IDLE;
                        end
                    end
                    IGNORE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        LadOe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lpc_io_target.sv
// Randomised LPC I/O-cycle bench for lpc_io_target with
// a per-clock transaction-level expectation queue.
module tb_lpc_io_target;
    localparam int W = 2;
    localparam logic [15:0] BASE = 16'h0800;
    localparam int L = 13 + W;
`ifdef LPC_IO_PORT80_EN
    localparam bit P80 = 1'b1;
`else
    localparam bit P80 = 1'b0;
`endif

    logic       LpcClock;
    logic       PciReset;
    logic       LpcFrame_n;
    logic [3:0] LadIn;
    logic [3:0] LadOut;
    logic       LadOe;
    logic [7:0] AddrReg;
    logic [7:0] DataWr;
    logic       WrStrobe;
    logic [7:0] DataRd;
    logic [7:0] Port80Code;
    logic       Port80Valid;

    lpc_io_target #(.BASE_ADDR(BASE), .SYNC_WAITS(W)) dut (
        .LpcClock(LpcClock), .PciReset(PciReset),
        .LpcFrame_n(LpcFrame_n), .LadIn(LadIn),
        .LadOut(LadOut), .LadOe(LadOe),
        .AddrReg(AddrReg), .DataWr(DataWr),
        .WrStrobe(WrStrobe), .DataRd(DataRd),
        .Port80Code(Port80Code), .Port80Valid(Port80Valid)
    );

    initial LpcClock = 1'b0;
    always #15 LpcClock = ~LpcClock;

    // register-file stub: registered read mux
    logic [7:0] mem [32];
    always @(posedge LpcClock) DataRd <= mem[AddrReg[4:0]];

    typedef struct {
        int         cyc;
        logic       oe;
        logic [3:0] lad;
        logic       ws;
        logic [7:0] ar;
        logic [7:0] dw;
        logic [7:0] pc;
        logic       pv;
    } exp_t;

    exp_t q[$];
    exp_t ce;
    int cyc = 0;
    int nCmp = 0;
    int nBad = 0;
    logic [7:0] mAr = 8'h00;
    logic [7:0] mDw = 8'h00;
    logic [7:0] mPc = 8'h00;

    logic [31:0] drvv = 32'h0;
    int drvN = 0;
    int nStrobe = 0;
    int nP80 = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge LpcClock) cyc <= cyc + 1;

    always @(negedge LpcClock) begin
        if (LadOe) begin
            drvv <= {drvv[27:0], LadOut};
            drvN <= drvN + 1;
        end
        if (WrStrobe) nStrobe <= nStrobe + 1;
        if (Port80Valid) nP80 <= nP80 + 1;
    end

    always @(negedge LpcClock) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            ce = q.pop_front();
            check("LadOe", LadOe, ce.oe);
            if (ce.oe) check("LadOut", LadOut, ce.lad);
            check("WrStrobe", WrStrobe, ce.ws);
            check("AddrReg", AddrReg, ce.ar);
            check("DataWr", DataWr, ce.dw);
            check("Port80Code", Port80Code, ce.pc);
            check("Port80Valid", Port80Valid, ce.pv);
        end
    end

    task automatic drive(input logic fr, input logic [3:0] nib,
                         input logic oe, input logic [3:0] lad,
                         input logic ws, input logic pv);
        exp_t e;
        LpcFrame_n = fr;
        LadIn = nib;
        e.cyc = cyc + 1;
        e.oe = oe; e.lad = lad; e.ws = ws; e.pv = pv;
        e.ar = mAr; e.dw = mDw; e.pc = mPc;
        q.push_back(e);
        @(negedge LpcClock);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0);
    endtask

    task automatic txn(input logic [3:0] ct, input logic [15:0] a,
                       input logic [7:0] d, input int abortAt,
                       input bit restart, input int resetAt);
        logic [3:0] nib [L];
        logic [3:0] seq [24];
        logic [7:0] rd;
        bit isRd, isWr, hit, snp, oe;
        int s, len, c;
        logic [3:0] lad;
        isRd = ct[3:1] == 3'b000;
        isWr = ct[3:1] == 3'b001;
        snp = P80 && isWr && a == 16'h0080;
        hit = (isRd || isWr) && !snp && a[15:5] == BASE[15:5];
        rd = mem[a[4:0]];
        for (int i = 0; i < L; i++) nib[i] = 4'hF;
        nib[0] = 4'h0; nib[1] = ct;
        nib[2] = a[15:12]; nib[3] = a[11:8];
        nib[4] = a[7:4]; nib[5] = a[3:0];
        if (isWr) begin
            nib[6] = d[3:0];
            nib[7] = d[7:4];
        end
        for (int k = 0; k < W; k++) seq[k] = 4'h6;
        seq[W] = 4'h0;
        if (isRd) begin
            seq[W + 1] = rd[3:0];
            seq[W + 2] = rd[7:4];
            seq[W + 3] = 4'hF;
            len = W + 4;
        end else begin
            seq[W + 1] = 4'hF;
            len = W + 2;
        end
        s = isWr ? 10 : 8;
        for (int i = 0; i < L; i++) begin
            if (i == resetAt) begin
                #5;
                check("pre_rst_LadOe", LadOe, 1'b1);
                PciReset = 1'b0;
                #1;
                check("rst_LadOe", LadOe, 1'b0);
                check("rst_LadOut", LadOut, 4'hF);
                check("rst_AddrReg", AddrReg, 8'h00);
                q.delete();
                mAr = 8'h00; mDw = 8'h00; mPc = 8'h00;
                @(negedge LpcClock);
                LpcFrame_n = 1'b1;
                LadIn = 4'hF;
                PciReset = 1'b1;
                return;
            end
            if (i == abortAt) begin
                if (!restart) begin
                    repeat ($urandom_range(1, 4))
                        drive(1'b0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0);
                    idle(1);
                end
                return;
            end
            c = i + 1;
            if (hit && i == 5) mAr = {3'b000, a[4:0]};
            if (hit && isWr && i == 7) mDw = d;
            if (snp && i == 7) mPc = d;
            oe = hit && c >= s && c < s + len;
            lad = 4'hF;
            if (oe) lad = seq[c - s];
            drive((i == 0) ? 1'b0 : 1'b1, nib[i], oe, lad,
                  hit && isWr && c == 8, snp && c == 8);
        end
    endtask

    task automatic mark();
        #5;
        drvv = 32'h0;
        drvN = 0;
    endtask

    int s0, p0;

    initial begin
        PciReset = 1'b0;
        LpcFrame_n = 1'b1;
        LadIn = 4'hF;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[4] = 8'h03;
        repeat (2) @(negedge LpcClock);
        check("reset_LadOe", LadOe, 1'b0);
        check("reset_LadOut", LadOut, 4'hF);
        check("reset_AddrReg", AddrReg, 8'h00);
        check("reset_DataWr", DataWr, 8'h00);
        check("reset_WrStrobe", WrStrobe, 1'b0);
        check("reset_P80Code", Port80Code, 8'h00);
        check("reset_P80Valid", Port80Valid, 1'b0);
        PciReset = 1'b1;
        idle(2);

        mark(); s0 = nStrobe;
        txn(4'h2, 16'h0805, 8'h5A, -1, 1'b0, -1);
        idle(2); #5;
        check("wr_lad_seq", drvv, 32'h0000660F);
        check("wr_lad_cnt", drvN, 4);
        check("wr_addr", AddrReg, 8'h05);
        check("wr_data", DataWr, 8'h5A);
        check("wr_strobes", nStrobe - s0, 1);

        mark(); s0 = nStrobe;
        txn(4'h0, 16'h0804, 8'h00, -1, 1'b0, -1);
        idle(2); #5;
        check("rd_lad_seq", drvv, 32'h0066030F);
        check("rd_lad_cnt", drvN, 6);
        check("rd_addr", AddrReg, 8'h04);
        check("rd_strobes", nStrobe - s0, 0);

        mark(); s0 = nStrobe;
        txn(4'h0, 16'h0900, 8'h00, -1, 1'b0, -1);
        txn(4'h4, 16'h0805, 8'h77, -1, 1'b0, -1);
        txn(4'h2, 16'h1805, 8'h77, -1, 1'b0, -1);
        idle(2); #5;
        check("miss_lad_cnt", drvN, 0);
        check("miss_strobes", nStrobe - s0, 0);
        check("miss_addr_held", AddrReg, 8'h04);

        mark(); s0 = nStrobe;
        txn(4'h2, 16'h0806, 8'h99, 4, 1'b0, -1);
        check("abort_addr_held", AddrReg, 8'h04);
        txn(4'h2, 16'h081F, 8'hC3, -1, 1'b0, -1);
        idle(1); #5;
        check("abort_lad_seq", drvv, 32'h0000660F);
        check("abort_next_addr", AddrReg, 8'h1F);
        check("abort_next_data", DataWr, 8'hC3);
        check("abort_strobes", nStrobe - s0, 1);

        mark(); s0 = nStrobe;
        txn(4'h0, 16'h0802, 8'h00, 9, 1'b1, -1);
        txn(4'h2, 16'h0803, 8'h3C, -1, 1'b0, -1);
        idle(1); #5;
        check("restart_data", DataWr, 8'h3C);
        check("restart_strobes", nStrobe - s0, 1);

        mark(); p0 = nP80; s0 = nStrobe;
        txn(4'h2, 16'h0080, 8'h55, -1, 1'b0, -1);
        idle(2); #5;
        check("p80_lad_cnt", drvN, 0);
        check("p80_strobes", nStrobe - s0, 0);
`ifdef LPC_IO_PORT80_EN
        check("p80_code", Port80Code, 8'h55);
        check("p80_pulses", nP80 - p0, 1);
`else
        check("p80_code", Port80Code, 8'h00);
        check("p80_pulses", nP80 - p0, 0);
`endif

        txn(4'h0, 16'h0807, 8'h00, -1, 1'b0, 9);
        idle(2); #5;
        check("post_rst_AddrReg", AddrReg, 8'h00);
        check("post_rst_LadOe", LadOe, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int r, aa;
            logic [3:0] ct;
            logic [15:0] a;
            bit rs;
            r = $urandom_range(0, 9);
            if (r < 4) ct = {3'b000, 1'($urandom)};
            else if (r < 8) ct = {3'b001, 1'($urandom)};
            else ct = 4'($urandom_range(4, 15));
            r = $urandom_range(0, 9);
            if (r < 6) a = BASE | 16'($urandom_range(0, 31));
            else if (r < 7) a = 16'h0080;
            else a = 16'($urandom);
            aa = -1;
            if ($urandom_range(0, 4) == 0) aa = $urandom_range(1, L - 1);
            rs = 1'($urandom);
            txn(ct, a, 8'($urandom), aa, rs, -1);
            if (!(aa >= 0 && rs)) idle($urandom_range(0, 2));
        end
        idle(3);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end
endmodule
